serial_add4: RTL and testbench

//   Bit-serial add/subtract unit built around one add1 full-adder cell.

---
 rtl/alu4_pkg.sv | 14 +
 rtl/add1.sv | 18 +
 rtl/serial_add4.sv | 122 ++++++++++++
 tb/tb_serial_add4.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu4_pkg.sv
// Shared definitions for the bit-serial add/subtract unit.
//   serial_state_t : FSM state encoding (IDLE, RUN, DONE)
//   ALU_WIDTH      : default operand/result width
package alu4_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } serial_state_t;

    localparam int ALU_WIDTH = 4;

endpackage

// File: rtl/add1.sv
// One-bit combinational full adder: the arithmetic cell stepped by serial_add4.
// Ports:
//   a, b       in  1  operand bits
//   carry_in   in  1  incoming carry
//   out        out 1  sum bit
//   carry_out  out 1  outgoing carry
module add1 (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic out,
    output logic carry_out
);

    assign out       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/serial_add4.sv
// Bit-serial add/subtract unit. Operands are latched on start&&ready and fed
// LSB first through one add1 cell, one bit per clock; the cell's carry is
// registered and fed back as the next bit's carry-in.
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous reset, active-low
//   start      in   1      request, sampled only while ready
//   sub        in   1      0: a+b, 1: a-b (two's complement)
//   a, b       in   WIDTH  operands
//   ready      out  1      IDLE
//   busy       out  1      RUN
//   done       out  1      DONE (one-cycle pulse)
//   sum        out  WIDTH  registered result, held until next completion
//   carry_out  out  1      final carry (for sub: 1 = no borrow)
//   overflow   out  1      signed overflow
module serial_add4
    import alu4_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    serial_state_t    state;
    serial_state_t    state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Only WIDTH-1 result bits need storing: the final bit comes straight
    // from the adder on the last step.
    logic [WIDTH-2:0] res_sh;
    logic [WIDTH-1:0] res_cat;
    logic             carry;
    logic             bit_sum;
    logic             bit_carry;

    add1 u_add1 (
        .a         (a_sh[0]),
        .b         (b_sh[0]),
        .carry_in  (carry),
        .out       (bit_sum),
        .carry_out (bit_carry)
    );

    assign res_cat = {bit_sum, res_sh};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (count == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign ready = (state == IDLE);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count     <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtraction: invert b here, the +1 enters as carry-in.
                        a_sh  <= a;
                        b_sh  <= sub ? ~b : b;
                        carry <= sub;
                        count <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_cat[WIDTH-1:1];
                    carry  <= bit_carry;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        sum       <= res_cat;
                        carry_out <= bit_carry;
                        // carry currently holds the carry into the MSB.
                        overflow  <= carry ^ bit_carry;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add4.sv
// Self-checking bench for serial_add4: directed cases, an abort by reset, and
// an exhaustive randomly ordered sweep of a/b/sub with random start noise.
module tb_serial_add4;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int unsigned  c0;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    int unsigned  cyc;
    int unsigned  n_checks;
    int unsigned  n_fail;
    bit           mon_on;
    exp_t         sb_q[$];
    exp_t         held;

    serial_add4 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input int unsigned ua, input int unsigned ub, input bit s);
        exp_t        r;
        int          sa;
        int          sbv;
        int          sr;
        int unsigned ur;
        sa  = (ua >= 8) ? int'(ua) - 16 : int'(ua);
        sbv = (ub >= 8) ? int'(ub) - 16 : int'(ub);
        if (s) begin
            ur     = ua + 16 - ub;
            r.cout = (ua >= ub);
            sr     = sa - sbv;
        end else begin
            ur     = ua + ub;
            r.cout = (ur >= 16);
            sr     = sa + sbv;
        end
        r.sum = W'(ur % 16);
        r.ovf = (sr > 7) || (sr < -8);
        r.c0  = 0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // noise: 0 = start low while busy, 1 = random start/operands, 2 = start with a=1,b=1.
    task automatic issue(input int unsigned ua, input int unsigned ub, input bit s, input int noise);
        exp_t        e;
        int unsigned w;
        w = 0;
        while (!ready && w < 20) begin
            tick();
            w++;
        end
        chk("ready_wait", ready, 1);
        if (!ready) return;
        a     = W'(ua);
        b     = W'(ub);
        sub   = s;
        start = 1'b1;
        e     = model(ua, ub, s);
        tick();
        e.c0  = cyc;
        sb_q.push_back(e);
        start = 1'b0;
        for (int i = 0; i <= W; i++) begin
            if (noise == 1) begin
                start = 1'($urandom);
                a     = W'($urandom);
                b     = W'($urandom);
                sub   = 1'($urandom);
            end else if (noise == 2) begin
                start = 1'b1;
                a     = W'(1);
                b     = W'(1);
                sub   = 1'b0;
            end
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        int unsigned order[2*16*16];
        int unsigned j;
        int unsigned tmp;

        n_checks = 0;
        n_fail   = 0;
        mon_on   = 0;
        held     = '{sum: '0, cout: 1'b0, ovf: 1'b0, c0: 0};
        rst_n    = 1'b0;
        start    = 1'b0;
        sub      = 1'b0;
        a        = '0;
        b        = '0;

        fork
            begin
                #600000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "timeout");
            end
            begin
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (mon_on && rst_n) begin
                        chk("state_onehot", 32'($countones({ready, busy, done})), 1);
                        if (done) begin
                            if (sb_q.size() == 0) begin
                                chk("unexpected_done", 1, 0);
                            end else begin
                                e = sb_q.pop_front();
                                chk("done_sum", sum, e.sum);
                                chk("done_carry_out", carry_out, e.cout);
                                chk("done_overflow", overflow, e.ovf);
                                // done is visible right after edge E_W.
                                chk("done_latency", cyc - e.c0, W);
                                held = e;
                            end
                        end else begin
                            chk("held_sum", sum, held.sum);
                            chk("held_carry_out", carry_out, held.cout);
                            chk("held_overflow", overflow, held.ovf);
                        end
                    end
                end
            end
        join_none

        // Reset state
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_carry_out", carry_out, 0);
        chk("rst_overflow", overflow, 0);
        mon_on = 1;

        // Directed arithmetic cases
        issue(3, 5, 0, 0);
        issue(15, 1, 0, 0);
        issue(7, 1, 0, 0);
        issue(5, 3, 1, 0);
        issue(3, 5, 1, 0);
        // start held high with new operands through RUN and DONE
        issue(3, 5, 0, 2);
        issue(9, 2, 1, 0);

        // Abort with reset at count=2
        a     = W'(6);
        b     = W'(7);
        sub   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        sb_q.delete();
        held  = '{sum: '0, cout: 1'b0, ovf: 1'b0, c0: 0};
        tick();
        rst_n = 1'b1;
        chk("abort_ready", ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_sum", sum, 0);
        repeat (W + 2) tick();
        issue(2, 2, 0, 0);

        // Exhaustive sweep in random order
        for (int unsigned i = 0; i < 512; i++) order[i] = i;
        for (int unsigned i = 511; i > 0; i--) begin
            j        = $urandom_range(i, 0);
            tmp      = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        for (int unsigned i = 0; i < 512; i++) begin
            issue(order[i] & 15, (order[i] >> 4) & 15, order[i][8], int'($urandom_range(1, 0)));
            repeat ($urandom_range(2, 0)) tick();
        end

        repeat (4) tick();
        chk("queue_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
